// File: rtl/hex_entry_ctrl_pkg.sv
// Shared types and constants for the front-panel hex entry controller.
package hex_entry_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam int DIGITS    = 6;
    localparam int DISP_W    = 24;
    localparam int NIBBLE_W  = 4;
    localparam int NUM_HEX   = 16;
    localparam int KEY_ENTER = 16;
    localparam int KEY_CLEAR = 17;
    localparam int NUM_KEYS  = 18;

    // Lowest-numbered hex key wins when several press together.
    function automatic logic [NIBBLE_W-1:0] lowest_hex(input logic [NUM_HEX-1:0] keys);
        logic [NIBBLE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_HEX - 1; i >= 0; i--) begin
            if (keys[i]) begin
                idx = NIBBLE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_entry_ctrl_debounce.sv
// One key: 2-flop synchroniser, tick-sampled debounce, single-cycle press pulse.
module hex_entry_ctrl_debounce #(
    parameter int DB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic press
);

    localparam int CW = $clog2(DB_SAMPLES + 1);

    logic [1:0]    sync_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (tick) begin
            if (sync_q[1] != state_q) begin
                if (cnt_q == CW'(DB_SAMPLES - 1)) begin
                    state_d = sync_q[1];
                    cnt_d   = '0;
                    press_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hex_entry_ctrl.sv
// Front-panel entry controller: debounced keypad, 6-digit hex editor, commit handshake.
module hex_entry_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stopped,
    input  logic [15:0] b_hex,
    input  logic        b_enter,
    input  logic        b_clear,
    input  logic [23:0] live,
    input  logic        live_valid,
    output logic [23:0] disp,
    output logic        disp_valid,
    output logic [2:0]  digit_cnt,
    output logic [23:0] entry_data,
    output logic        entry_valid,
    input  logic        entry_ready
);

    import hex_entry_ctrl_pkg::*;

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] press;

    state_e              state_q, state_d;
    logic [DISP_W-1:0]   entry_q, entry_d;
    logic [DISP_W-1:0]   entry_data_q, entry_data_d;
    logic                entry_valid_q, entry_valid_d;
    logic [2:0]          digit_cnt_q, digit_cnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                disp_valid_q, disp_valid_d;
    logic [NIBBLE_W-1:0] hex_key;

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    assign tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign key_raw = {b_clear, b_enter, b_hex};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        hex_entry_ctrl_debounce #(
            .DB_SAMPLES(DB_SAMPLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .key_raw(key_raw[g]),
            .press  (press[g])
        );
    end

    assign hex_key = lowest_hex(press[NUM_HEX-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q    <= '0;
            state_q       <= IDLE;
            entry_q       <= '0;
            entry_data_q  <= '0;
            entry_valid_q <= 1'b0;
            digit_cnt_q   <= '0;
            disp_q        <= '0;
            disp_valid_q  <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            entry_q       <= entry_d;
            entry_data_q  <= entry_data_d;
            entry_valid_q <= entry_valid_d;
            digit_cnt_q   <= digit_cnt_d;
            disp_q        <= disp_d;
            disp_valid_q  <= disp_valid_d;
        end
    end

    // Events are already prioritised CLEAR > ENTER > hex; an event in EDIT takes
    // precedence over abandoning the edit when stopped falls.
    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        entry_data_d  = entry_data_q;
        entry_valid_d = entry_valid_q;
        digit_cnt_d   = digit_cnt_q;
        case (state_q)
            IDLE: begin
                if (stopped) begin
                    state_d     = EDIT;
                    entry_d     = live;
                    digit_cnt_d = '0;
                end
            end
            EDIT: begin
                if (press[KEY_CLEAR]) begin
                    entry_d     = '0;
                    digit_cnt_d = '0;
                end else if (press[KEY_ENTER]) begin
                    entry_data_d  = entry_q;
                    entry_valid_d = 1'b1;
                    state_d       = COMMIT;
                end else if (|press[NUM_HEX-1:0]) begin
                    if (digit_cnt_q == '0) begin
                        entry_d = {{(DISP_W - NIBBLE_W){1'b0}}, hex_key};
                    end else begin
                        entry_d = {entry_q[DISP_W-NIBBLE_W-1:0], hex_key};
                    end
                    if (digit_cnt_q != 3'(DIGITS)) begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end else if (!stopped) begin
                    entry_d     = '0;
                    digit_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            COMMIT: begin
                if (entry_ready) begin
                    entry_valid_d = 1'b0;
                    digit_cnt_d   = '0;
                    state_d       = stopped ? EDIT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Display tracks next-state values so it moves on the same edge as entry.
        case (state_d)
            IDLE: begin
                disp_d       = live;
                disp_valid_d = live_valid;
            end
            EDIT: begin
                disp_d       = entry_d;
                disp_valid_d = 1'b1;
            end
            default: begin
                disp_d       = entry_data_d;
                disp_valid_d = 1'b1;
            end
        endcase
    end

    assign disp        = disp_q;
    assign disp_valid  = disp_valid_q;
    assign digit_cnt   = digit_cnt_q;
    assign entry_data  = entry_data_q;
    assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Self-checking bench for hex_entry_ctrl: directed scenarios plus randomized key/handshake traffic.
module tb_hex_entry_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int DB_SAMPLES = 2;
    localparam int HOLD       = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stopped = 1'b0;
    logic [15:0] b_hex = '0;
    logic        b_enter = 1'b0;
    logic        b_clear = 1'b0;
    logic [23:0] live = 24'hABCDEF;
    logic        live_valid = 1'b1;
    logic        entry_ready = 1'b0;
    logic [23:0] disp;
    logic        disp_valid;
    logic [2:0]  digit_cnt;
    logic [23:0] entry_data;
    logic        entry_valid;

    hex_entry_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DB_SAMPLES(DB_SAMPLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stopped    (stopped),
        .b_hex      (b_hex),
        .b_enter    (b_enter),
        .b_clear    (b_clear),
        .live       (live),
        .live_valid (live_valid),
        .disp       (disp),
        .disp_valid (disp_valid),
        .digit_cnt  (digit_cnt),
        .entry_data (entry_data),
        .entry_valid(entry_valid),
        .entry_ready(entry_ready)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int n_xfer = 0;

    // Behavioural model: mode 0 = showing live, 1 = editing, 2 = offering a commit.
    int          m_mode = 0;
    logic [23:0] m_entry = '0;
    logic [23:0] m_data = '0;
    int          m_digits = 0;
    bit          m_valid = 1'b0;
    bit          settled = 1'b0;
    logic [23:0] exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] expDisp();
        if (m_mode == 0) return live;
        if (m_mode == 1) return m_entry;
        return m_data;
    endfunction

    function automatic logic expDispValid();
        return (m_mode == 0) ? live_valid : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst && settled) begin
            checkOutput("disp", 32'(disp), 32'(expDisp()));
            checkOutput("disp_valid", 32'(disp_valid), 32'(expDispValid()));
            checkOutput("digit_cnt", 32'(digit_cnt), 32'(m_digits));
            checkOutput("entry_valid", 32'(entry_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("entry_data", 32'(entry_data), 32'(m_data));
            end
        end
        if (!rst && entry_valid && entry_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL transfer: got data %h expected no transfer", entry_data);
            end else begin
                checkOutput("transfer_data", 32'(entry_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyEvent(input logic [17:0] m);
        int k;
        longint v;
        if (m_mode != 1) return;
        if (m[17]) begin
            m_entry  = '0;
            m_digits = 0;
        end else if (m[16]) begin
            m_data  = m_entry;
            m_valid = 1'b1;
            m_mode  = 2;
            exp_q.push_back(m_entry);
        end else if (m[15:0] != '0) begin
            k = 0;
            while (!m[k]) k++;
            if (m_digits == 0) v = k;
            else v = (longint'(m_entry) * 16 + k) % (longint'(1) << 24);
            m_entry = 24'(v);
            if (m_digits < 6) m_digits++;
        end
        if (m_mode == 1 && !stopped) begin
            m_mode   = 0;
            m_entry  = '0;
            m_digits = 0;
        end
    endtask

    task automatic applyStimulus(input logic [17:0] m);
        settled = 1'b0;
        {b_clear, b_enter, b_hex} = m;
        waitCycles(HOLD);
        applyEvent(m);
        settled = 1'b1;
        {b_clear, b_enter, b_hex} = '0;
        waitCycles(HOLD);
    endtask

    task automatic setStopped(input bit v);
        settled = 1'b0;
        stopped = v;
        waitCycles(2);
        if (v && m_mode == 0) begin
            m_mode   = 1;
            m_entry  = live;
            m_digits = 0;
        end else if (!v && m_mode == 1) begin
            m_mode   = 0;
            m_entry  = '0;
            m_digits = 0;
        end
        settled = 1'b1;
    endtask

    task automatic acceptCommit();
        settled = 1'b0;
        entry_ready = 1'b1;
        waitCycles(1);
        entry_ready = 1'b0;
        if (m_mode == 2) begin
            m_valid  = 1'b0;
            m_digits = 0;
            m_mode   = stopped ? 1 : 0;
        end
        waitCycles(2);
        settled = 1'b1;
    endtask

    task automatic setLive(input logic [23:0] v, input bit vld);
        settled = 1'b0;
        live = v;
        live_valid = vld;
        waitCycles(2);
        settled = 1'b1;
    endtask

    task automatic readyNoise();
        if (m_valid) return;
        for (int i = 0; i < 8; i++) begin
            entry_ready = 1'($urandom_range(0, 1));
            waitCycles(1);
        end
        entry_ready = 1'b0;
        waitCycles(1);
    endtask

    function automatic logic [17:0] hexMask(input int k);
        logic [17:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [17:0] mask;
        int xfer_before;

        // Reset values while rst is held.
        waitCycles(3);
        checkOutput("rst_disp", 32'(disp), 32'h0);
        checkOutput("rst_disp_valid", 32'(disp_valid), 32'h0);
        checkOutput("rst_entry_valid", 32'(entry_valid), 32'h0);
        checkOutput("rst_digit_cnt", 32'(digit_cnt), 32'h0);
        rst = 1'b0;
        waitCycles(2);
        settled = 1'b1;
        checkOutput("idle_disp", 32'(disp), 32'hABCDEF);
        checkOutput("idle_disp_valid", 32'(disp_valid), 32'h1);

        applyStimulus(hexMask(3));
        checkOutput("idle_ignores_key", 32'(disp), 32'hABCDEF);

        // Entry of three digits, then a glitch that must be filtered.
        setStopped(1'b1);
        checkOutput("edit_disp_live", 32'(disp), 32'hABCDEF);
        applyStimulus(hexMask(1));
        applyStimulus(hexMask(2));
        applyStimulus(hexMask(3));
        checkOutput("entry_123", 32'(disp), 32'h000123);
        checkOutput("cnt_3", 32'(digit_cnt), 32'd3);
        b_hex[5] = 1'b1;
        waitCycles(2);
        b_hex[5] = 1'b0;
        waitCycles(HOLD);
        checkOutput("glitch_filtered", 32'(disp), 32'h000123);

        // Seven digits: the first one scrolls off, count saturates.
        applyStimulus(hexMask(17));
        for (int k = 1; k <= 7; k++) applyStimulus(hexMask(k));
        checkOutput("wrap_disp", 32'(disp), 32'h234567);
        checkOutput("wrap_cnt", 32'(digit_cnt), 32'd6);

        // Arbitration.
        applyStimulus(hexMask(17));
        applyStimulus(hexMask(9) | hexMask(4));
        checkOutput("arb_lowest_hex", 32'(disp), 32'h000004);
        applyStimulus(hexMask(17) | hexMask(16));
        checkOutput("arb_clear_disp", 32'(disp), 32'h0);
        checkOutput("arb_clear_no_commit", 32'(entry_valid), 32'h0);

        // Handshake with a stalled consumer and stopped falling mid-wait.
        applyStimulus(hexMask(11));
        applyStimulus(hexMask(14));
        applyStimulus(hexMask(14));
        applyStimulus(hexMask(15));
        checkOutput("beef_disp", 32'(disp), 32'h00BEEF);
        xfer_before = n_xfer;
        applyStimulus(hexMask(16));
        waitCycles(5);
        setStopped(1'b0);
        waitCycles(5);
        checkOutput("hold_valid", 32'(entry_valid), 32'h1);
        checkOutput("hold_data", 32'(entry_data), 32'h00BEEF);
        acceptCommit();
        checkOutput("one_transfer", 32'(n_xfer - xfer_before), 32'd1);
        checkOutput("after_accept_valid", 32'(entry_valid), 32'h0);
        checkOutput("after_accept_disp", 32'(disp), 32'hABCDEF);

        // Randomized traffic against the model.
        for (int it = 0; it < 90; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                mask = '0;
                for (int j = 0; j < $urandom_range(1, 2); j++) begin
                    int p;
                    p = $urandom_range(0, 19);
                    if (p < 16) mask[p] = 1'b1;
                    else if (p < 18) mask[16] = 1'b1;
                    else mask[17] = 1'b1;
                end
                applyStimulus(mask);
            end else if (r == 5) begin
                setStopped($urandom_range(0, 3) != 0);
            end else if (r == 6) begin
                acceptCommit();
            end else if (r == 7) begin
                if (m_mode == 0) setLive(24'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                readyNoise();
            end
        end
        if (m_valid) acceptCommit();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a commit is pending.
        setStopped(1'b1);
        applyStimulus(hexMask(10));
        applyStimulus(hexMask(16));
        checkOutput("pre_reset_valid", 32'(entry_valid), 32'h1);
        settled = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(entry_valid), 32'h0);
        checkOutput("async_rst_disp", 32'(disp), 32'h0);
        checkOutput("async_rst_cnt", 32'(digit_cnt), 32'h0);
        stopped = 1'b0;
        m_mode = 0;
        m_entry = '0;
        m_data = '0;
        m_digits = 0;
        m_valid = 1'b0;
        exp_q.delete();
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        settled = 1'b1;
        waitCycles(4);
        checkOutput("post_rst_disp", 32'(disp), 32'(live));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hex_entry_ctrl.md
Name: hex_entry_ctrl

Overview:
- Front-panel entry controller for the 16-key hex pad and the 24-bit display.
- Debounces the 16 hex keys plus ENTER and CLEAR, and serialises simultaneous presses.
- While the CPU is stopped, builds a 6-digit hex value on the display. While running, shows a live value.
- Hands committed values to the downstream monitor logic over a valid/ready handshake.

Parameters:
- TICK_DIV, 50000: clk cycles per debounce sample tick (>=2).
- DB_SAMPLES, 4: consecutive equal samples required to change a debounced key state (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- stopped  in  1  CPU halted; level.
- b_hex  in  16  raw hex keys, bit n = key n, active-high, asynchronous.
- b_enter  in  1  raw ENTER key.
- b_clear  in  1  raw CLEAR key.
- live  in  24  value shown while running.
- live_valid  in  1  live is meaningful.
- disp  out  24  display value.
- disp_valid  out  1  display content valid.
- digit_cnt  out  3  digits entered in current edit, 0..6.
- entry_data  out  24  committed value.
- entry_valid  out  1  commit offer.
- entry_ready  in  1  downstream accepts.

Interface (already decided): one clock, `clk`. `rst` is asynchronous, active-high.

Behaviour:
- Reset values: disp=0, disp_valid=0, digit_cnt=0, entry_data=0, entry_valid=0, state=IDLE, all debounced states=0, tick counter=0.
- Input sync: each raw key passes a 2-flop synchroniser.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses `tick` for 1 cycle at wrap.
- Debounce:
  - On each tick a key samples its synchronised level.
  - After DB_SAMPLES consecutive samples differing from the current debounced state, the state flips.
  - A 0->1 flip produces a 1-cycle press event. Releases produce no event.
- Arbitration, same cycle:
  - CLEAR beats ENTER, which beats hex keys.
  - Among hex keys, the lowest index wins.
  - Losing events are dropped, not queued.
- State machine:
  - IDLE:
    - disp=live, disp_valid=live_valid. All events ignored.
    - stopped=1 -> EDIT with entry<=live, digit_cnt<=0.
  - EDIT: disp=entry, disp_valid=1.
    - Hex key k, digit_cnt=0: entry<={20'h0,k}, digit_cnt<=1.
    - Hex key k, digit_cnt>0: entry<={entry[19:0],k}.
    - digit_cnt saturates at 6. A 7th and later digit still shifts, discarding the top nibble.
    - CLEAR: entry<=0, digit_cnt<=0.
    - ENTER: entry_data<=entry, entry_valid<=1 -> COMMIT.
    - stopped=0 without an event: entry<=0, digit_cnt<=0 -> IDLE (edit abandoned).
  - COMMIT: disp=entry_data, disp_valid=1.
    - All key events are ignored.
    - entry_valid and entry_data hold stable until entry_valid&entry_ready. They are never retracted, even if stopped falls.
    - On accept: entry_valid<=0, digit_cnt<=0, next state EDIT if stopped=1, else IDLE.
- Latency:
  - Key event is registered; entry/disp update on the next clk edge.
  - Raw edge to event: 2 clk sync + DB_SAMPLES ticks (+1 partial tick).
- Simultaneity:
  - An ENTER event in the same cycle stopped falls takes ENTER (commit wins).
  - entry_ready while entry_valid=0 is ignored.
- Reset mid-operation: any state returns immediately to reset values; a pending commit is lost.

Decomposition:
- Shared package, e.g. ui_pkg:
  - state enum {IDLE, EDIT, COMMIT}.
  - Constants DIGITS=6, DISP_W=24, NIBBLE_W=4.
  - Key index constants KEY_ENTER=16, KEY_CLEAR=17.
- Sub-module key_debounce: synchroniser, sample shift/counter, press pulse.
  - Parameterised by DB_SAMPLES; takes `tick` from the shared prescaler.
  - Instantiated 18 times.
- The prescaler, arbiter and FSM live in the top.

Test Plan (TICK_DIV=4, DB_SAMPLES=2):
- Reset with live=24'hABCDEF, live_valid=1, stopped=0 -> disp=ABCDEF, disp_valid=1, entry_valid=0. Key 3 pressed -> disp unchanged.
- Entry: stopped=1 -> disp=ABCDEF. Keys 1,2,3 each held 20 cycles -> disp=000123, digit_cnt=3. A 2-cycle glitch on key 5 -> no change.
- Wrap: stopped=1, keys 1..7 pressed in order -> disp=234567, digit_cnt=6.
- Arbitration: keys 9 and 4 rise in the same cycle from digit_cnt=0 -> disp=000004. CLEAR+ENTER together -> disp=0, entry_valid=0.
- Handshake: after entering 00BEEF, ENTER with entry_ready=0 for 10 cycles, stopped dropped mid-wait -> entry_valid=1, entry_data=00BEEF stable. entry_ready=1 -> one transfer, then IDLE, disp=live.
- Async reset asserted in COMMIT -> entry_valid=0 and disp=0 immediately, without waiting for a clk edge.
